// File: rtl/t_toggle_counter.sv
// t_toggle_counter: WIDTH-bit bank of T flip-flops with hold, per-bit toggle,
// modulo-up and modulo-down modes, parallel load and terminal-count pulse.
// Ports: clock, clear_ (sync active-low), en, mode, t, load, load_val -> q, tc, load_err.
// Macro T_TOGGLE_COUNTER_PARITY_EN adds registered output parity = ^q.
module t_toggle_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [32:0] MODULUS   = 33'd256,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clock,
  input  logic             clear_,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             load_err
`ifdef T_TOGGLE_COUNTER_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [WIDTH:0]   ONE   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   MOD   = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0]   TOP_W = MOD - ONE;
  localparam logic [WIDTH-1:0] TOP   = TOP_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST   = RESET_VAL[WIDTH-1:0];

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   lv_ext;
  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;
  logic             err_nxt;

  assign q_ext  = {1'b0, q};
  assign lv_ext = {1'b0, load_val};
  assign inc    = q_ext + ONE;
  // dec[WIDTH] is the borrow out, set exactly when q == 0
  assign dec    = q_ext - ONE;

  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (!clear_) begin
      q_nxt = RST;
    end else if (load) begin
      if (lv_ext < MOD) begin
        q_nxt = load_val;
      end else begin
        q_nxt   = TOP;
        err_nxt = 1'b1;
      end
    end else if (en) begin
      unique case (mode)
        2'b01: q_nxt = q ^ t;
        2'b10: begin
          // q+1 >= MOD covers q == MOD-1 and q above range
          if (inc >= MOD) begin
            q_nxt  = '0;
            tc_nxt = 1'b1;
          end else begin
            q_nxt = inc[WIDTH-1:0];
          end
        end
        2'b11: begin
          if (dec[WIDTH]) begin
            q_nxt  = TOP;
            tc_nxt = 1'b1;
          end else if (q_ext > TOP_W) begin
            q_nxt = TOP;
          end else begin
            q_nxt = dec[WIDTH-1:0];
          end
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    q        <= q_nxt;
    tc       <= tc_nxt;
    load_err <= err_nxt;
  end

`ifdef T_TOGGLE_COUNTER_PARITY_EN
  always_ff @(posedge clock) begin
    parity <= ^q_nxt;
  end
`endif

endmodule

// File: tb/tb_t_toggle_counter.sv
// Testbench for t_toggle_counter (WIDTH=4, MODULUS=10, RESET_VAL=0):
// directed vector table, a mid-cycle clear pulse, then random vs model.
module tb_t_toggle_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clock;
  logic         clear_;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         load_err;
`ifdef T_TOGGLE_COUNTER_PARITY_EN
  logic         parity;
`endif

  t_toggle_counter #(
    .WIDTH(W),
    .MODULUS(33'd10),
    .RESET_VAL(32'd0)
  ) dut (
    .clock(clock),
    .clear_(clear_),
    .en(en),
    .mode(mode),
    .t(t),
    .load(load),
    .load_val(load_val),
    .q(q),
    .tc(tc),
    .load_err(load_err)
`ifdef T_TOGGLE_COUNTER_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       c;
    logic       e;
    logic [1:0] md;
    logic [3:0] tv;
    logic       ld;
    logic [3:0] lv;
    int         eq;
    logic       etc;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int   mq = 0;
  logic mtc = 1'b0;
  logic merr = 1'b0;

  function automatic void add(logic c, logic e, logic [1:0] md, logic [3:0] tv,
                              logic ld, logic [3:0] lv, int eq, logic etc,
                              logic eerr);
    vec_t v;
    v.c = c; v.e = e; v.md = md; v.tv = tv; v.ld = ld; v.lv = lv;
    v.eq = eq; v.etc = etc; v.eerr = eerr;
    vecs.push_back(v);
  endfunction

  // next state computed directly from the behavioural rules
  task automatic model_step();
    mtc  = 1'b0;
    merr = 1'b0;
    if (!clear_) begin
      mq = 0;
    end else if (load) begin
      if (int'(load_val) < M) mq = int'(load_val);
      else begin
        mq   = M - 1;
        merr = 1'b1;
      end
    end else if (en && mode == 2'd1) begin
      mq = mq ^ int'(t);
    end else if (en && mode == 2'd2) begin
      if (mq >= M - 1) begin
        mq  = 0;
        mtc = 1'b1;
      end else mq = mq + 1;
    end else if (en && mode == 2'd3) begin
      if (mq == 0) begin
        mq  = M - 1;
        mtc = 1'b1;
      end else if (mq > M - 1) mq = M - 1;
      else mq = mq - 1;
    end
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(string tag, int eq, logic etc, logic eerr);
    logic [W-1:0] qv;
    check({tag, " q"}, int'(q), eq);
    check({tag, " tc"}, int'(tc), int'(etc));
    check({tag, " load_err"}, int'(load_err), int'(eerr));
`ifdef T_TOGGLE_COUNTER_PARITY_EN
    qv = W'(eq);
    check({tag, " parity"}, int'(parity), int'(^qv));
`else
    qv = '0;
    if (qv != '0) $display("unreachable");
`endif
  endtask

  task automatic edge_step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_ = 1'b0; en = 1'b1; mode = 2'd2; t = '0; load = 1'b0; load_val = '0;

    // reset
    add(0, 1, 2, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 0, 0, 0, 0, 0);
    // count up 12 edges
    for (int i = 1; i <= 12; i++)
      add(1, 1, 2, 0, 0, 0, i % M, (i == 10), 0);
    // load 3 then count down
    add(1, 1, 0, 0, 1, 3, 3, 0, 0);
    add(1, 1, 3, 0, 0, 0, 2, 0, 0);
    add(1, 1, 3, 0, 0, 0, 1, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 9, 1, 0);
    add(1, 1, 3, 0, 0, 0, 8, 0, 0);
    // toggle beyond modulus, then count up wraps
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 4'b1010, 0, 0, 10, 0, 0);
    add(1, 1, 2, 0, 0, 0, 0, 1, 0);
    // toggle beyond modulus, then count down clamps
    add(1, 1, 1, 4'b1010, 0, 0, 10, 0, 0);
    add(1, 1, 3, 0, 0, 0, 9, 0, 0);
    // toggle with t=0 and hold modes
    add(1, 1, 1, 0, 0, 0, 9, 0, 0);
    add(1, 1, 0, 4'hf, 0, 0, 9, 0, 0);
    add(1, 0, 2, 4'hf, 0, 0, 9, 0, 0);
    // out-of-range load, one-cycle error
    add(1, 0, 0, 0, 1, 12, 9, 0, 1);
    add(1, 0, 0, 0, 0, 0, 9, 0, 0);
    add(1, 0, 0, 0, 1, 15, 9, 0, 1);
    add(1, 0, 0, 0, 1, 10, 9, 0, 1);
    add(1, 0, 0, 0, 1, 9, 9, 0, 0);
    // load wins over counting
    add(1, 1, 2, 0, 1, 5, 5, 0, 0);
    add(1, 1, 2, 0, 0, 0, 6, 0, 0);
    // clear mid-count, then resume from reset value
    add(0, 1, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2, 0, 0, 0, 1, 0, 0);
    // clear beats load
    add(0, 1, 2, 0, 1, 7, 0, 0, 0);
    add(0, 1, 2, 0, 1, 12, 0, 0, 0);
    // parity samples
    add(1, 0, 0, 0, 1, 7, 7, 0, 0);
    add(1, 0, 0, 0, 1, 6, 6, 0, 0);

    @(negedge clock);
    foreach (vecs[i]) begin
      clear_ = vecs[i].c; en = vecs[i].e; mode = vecs[i].md;
      t = vecs[i].tv; load = vecs[i].ld; load_val = vecs[i].lv;
      edge_step();
      check_outs($sformatf("vec%0d", i), vecs[i].eq, vecs[i].etc, vecs[i].eerr);
      check($sformatf("vec%0d model", i), mq, vecs[i].eq);
    end

    // clear_ low pulse strictly between edges has no effect
    clear_ = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd4;
    edge_step();
    load = 1'b0;
    #2 clear_ = 1'b0;
    #2 clear_ = 1'b1;
    edge_step();
    check_outs("clr_pulse", 4, 1'b0, 1'b0);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      clear_   = ($urandom_range(0, 19) != 0);
      en       = ($urandom_range(0, 4) != 0);
      mode     = 2'($urandom_range(0, 3));
      t        = 4'($urandom_range(0, 15));
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      edge_step();
      check_outs($sformatf("rnd%0d", i), mq, mtc, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_toggle_counter.md
Name: t_toggle_counter

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of synchronous T flip-flops.
- Runs in one of four modes: hold, per-bit toggle, modulo-up count or modulo-down count.
- Also provides parallel load and a registered terminal-count pulse.
- Used as a general sequencer/divider wherever lab designs need toggle or counting state wider than one bit.

Parameters:
- WIDTH, 8, number of T flip-flop bits in q; legal range 1..32.
- MODULUS, 256, count wrap value; legal range 2..2^WIDTH; counting modes cycle through 0..MODULUS-1.
- RESET_VAL, 0, value loaded into q by clear_; must be < MODULUS.

Ports:
- clock  input  1  rising-edge clock; all state changes on posedge clock only.
- clear_  input  1  synchronous active-low clear; sampled on posedge clock.
- en  input  1  mode-operation enable; when 0, q holds (load still acts).
- mode  input  2  00 hold, 01 toggle-mask, 10 count up, 11 count down.
- t  input  WIDTH  per-bit toggle mask, used in mode 01 only.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  value for parallel load.
- q  output  WIDTH  registered flip-flop state.
- tc  output  1  registered terminal-count pulse.
- load_err  output  1  registered one-cycle flag: the last load was out of range.

Behaviour:
- Reset: synchronous, active-low. There is no asynchronous path; a negedge on clear_ between clock edges has no effect.
  - Clear result: q=RESET_VAL, tc=0, load_err=0 on the first posedge with clear_=0.
- Priority per edge: clear_ (low) > load > (en & mode) > hold.
- Load (load=1):
  - load_val < MODULUS: q<=load_val, load_err<=0.
  - Otherwise: q<=MODULUS-1, load_err<=1 for exactly one cycle.
  - tc<=0 on any load.
- Hold: en=0, or en=1 with mode=00. q unchanged, tc<=0.
- Toggle-mask (mode 01): q <= q XOR t, bitwise T-FF semantics.
  - MODULUS is not applied in this mode, so q may exceed MODULUS-1.
  - t=0 is a hold.
  - tc<=0.
- Count up (mode 10):
  - q < MODULUS-1: q<=q+1, tc<=0.
  - q >= MODULUS-1: q<=0, tc<=1.
- Count down (mode 11):
  - q == 0: q<=MODULUS-1, tc<=1.
  - q > MODULUS-1 (reached via toggle mode): q<=MODULUS-1, tc<=0.
  - Else: q<=q-1, tc<=0.
- Latency: one clock edge from inputs to q.
  - tc is registered in the same edge as the wrapped q value, so tc=1 is visible in the same cycle q shows the wrap value.
  - tc lasts exactly one cycle unless the next edge wraps again (MODULUS=2 counting gives back-to-back wraps).
- Arithmetic:
  - Increment/decrement is internally WIDTH+1 bits wide; no carry escapes.
  - MODULUS=2^WIDTH makes wrap identical to natural overflow.
- Simultaneous events:
  - load with en=1 in any mode: load wins, mode ignored.
  - clear_=0 with load=1: clear wins, load_err stays 0.
- Reset mid-count: next q=RESET_VAL regardless of mode. Counting resumes from RESET_VAL on the first edge with clear_=1.
- Fixed-state outputs: load_err and tc are 0 in every cycle not described above.

Optional Feature:
- Macro T_TOGGLE_COUNTER_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit), registered, equal to XOR-reduction of the q value that q takes on the same edge.
  - Reset value is ^RESET_VAL.
  - Tracks q in every mode, including load.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan (WIDTH=4, MODULUS=10, RESET_VAL=0 unless stated):
- Reset: clear_=0 for 2 edges with en=1, mode=10 -> q=0, tc=0, load_err=0. A clear_ low pulse between edges -> no change.
- Count up: from q=0, 12 edges -> q runs 1..9, 0, 1, 2. tc=1 only in the cycle q=0 after 9.
- Count down: load 3, then mode=11 for 5 edges -> q=2, 1, 0, 9, 8. tc=1 only in the cycle q=9.
- Toggle: q=0, mode=01, t=4'b1010 -> q=10 (beyond modulus). Next, mode=10 -> q=0 with tc=1. Repeat with mode=11 from q=10 -> q=9, tc=0.
- Load: load_val=12 -> q=9, load_err=1 for one cycle. load=1 with en=1, mode=10, load_val=5 -> q=5, not 6.
- Priority and parity: clear_=0 with load=1, load_val=7 -> q=0, load_err=0. With T_TOGGLE_COUNTER_PARITY_EN defined: q=7 -> parity=1, q=6 -> parity=0.
